// File: rtl/mem_stage_sb.sv
// Memory-access stage with a posted store buffer between execute and writeback.
// Stores retire into a small FIFO and drain in the background. Loads wait for same-word stores to drain first.
module mem_stage_sb #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4,
  parameter int IID_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [IID_W-1:0]            in_inst_id,
  input  logic [1:0]                  in_mem_op,
  input  logic [1:0]                  in_mem_size,
  input  logic                        in_fence,
  input  logic [XLEN-1:0]             in_addr,
  input  logic [XLEN-1:0]             in_wdata,
  output logic                        stall,
  output logic                        wb_valid,
  output logic [IID_W-1:0]            wb_inst_id,
  output logic [XLEN-1:0]             wb_rdata,
  output logic                        dreq_valid,
  input  logic                        dreq_ready,
  output logic                        dreq_wen,
  output logic [XLEN-1:0]             dreq_addr,
  output logic [XLEN-1:0]             dreq_wdata,
  output logic [1:0]                  dreq_size,
  input  logic                        dresp_valid,
  input  logic [XLEN-1:0]             dresp_rdata,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty
);

  // state     | meaning
  // S_IDLE    | pick next transaction, loads before buffered stores
  // S_LD_REQ  | load request on the bus
  // S_LD_RESP | waiting for load data
  // S_ST_REQ  | head store entry on the bus
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LD_REQ  = 2'd1;
  localparam logic [1:0] S_LD_RESP = 2'd2;
  localparam logic [1:0] S_ST_REQ  = 2'd3;

  localparam int PW  = $clog2(SB_DEPTH);
  localparam int CW  = PW + 1;
  localparam int OFS = $clog2(XLEN / 8);

  logic [XLEN-1:0]  r_sb_addr [SB_DEPTH];
  logic [XLEN-1:0]  r_sb_data [SB_DEPTH];
  logic [1:0]       r_sb_size [SB_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_done;
  logic [IID_W-1:0] r_done_id;
  logic [XLEN-1:0]  r_ld_addr;
  logic [1:0]       r_ld_size;
  logic             r_ld_signed;
  logic [IID_W-1:0] r_ld_id;
  logic             r_wb_valid;
  logic [IID_W-1:0] r_wb_id;
  logic [XLEN-1:0]  r_wb_rdata;

  logic             w_done;
  logic             w_is_st;
  logic             w_is_ld;
  logic             w_full;
  logic             w_sb_empty;
  logic             w_fence_hold;
  logic             w_push;
  logic             w_pop;
  logic             w_issue_ld;
  logic             w_capture;
  logic             w_conflict;
  logic [PW-1:0]    w_rel;
  logic [XLEN-1:0]  w_mask;
  logic             w_sbit;
  logic [XLEN-1:0]  w_ext;

  // The done flag only applies while the same instruction id is still presented.
  assign w_done       = r_done && (r_done_id == in_inst_id);
  assign w_is_st      = in_valid && (in_mem_op == 2'd1) && !w_done;
  assign w_is_ld      = in_valid && in_mem_op[1] && !w_done;
  assign w_full       = (r_count == CW'(SB_DEPTH));
  assign w_sb_empty   = (r_count == '0) && (r_state != S_ST_REQ);
  assign w_fence_hold = in_valid && in_fence && !w_sb_empty;
  assign w_push       = w_is_st && !w_full && !w_fence_hold;
  assign w_pop        = (r_state == S_ST_REQ) && dreq_ready;
  assign w_issue_ld   = (r_state == S_IDLE) && w_is_ld && !w_conflict;
  assign w_capture    = (r_state == S_LD_RESP) && dresp_valid;

  assign stall = w_is_ld || (w_is_st && w_full) || w_fence_hold;

  always_comb begin
    w_conflict = 1'b0;
    w_rel      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_rel = PW'(i) - r_rd_ptr;
      if (({1'b0, w_rel} < r_count) &&
          (r_sb_addr[i][XLEN-1:OFS] == in_addr[XLEN-1:OFS]))
        w_conflict = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_is_ld && !w_conflict) w_state_nxt = S_LD_REQ;
        else if (r_count != '0)     w_state_nxt = S_ST_REQ;
      end
      S_LD_REQ:  if (dreq_ready)  w_state_nxt = S_LD_RESP;
      S_LD_RESP: if (dresp_valid) w_state_nxt = S_IDLE;
      S_ST_REQ:  if (dreq_ready)  w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Mask-and-fill extension; a full-width mask makes the access a pass-through.
  always_comb begin
    w_mask = '1;
    w_sbit = 1'b0;
    case (r_ld_size)
      2'd0: begin w_mask = XLEN'(8'hFF);         w_sbit = dresp_rdata[7];  end
      2'd1: begin w_mask = XLEN'(16'hFFFF);      w_sbit = dresp_rdata[15]; end
      2'd2: begin w_mask = XLEN'(32'hFFFF_FFFF); w_sbit = dresp_rdata[31]; end
      default: begin w_mask = '1;                w_sbit = 1'b0;            end
    endcase
    w_ext = (dresp_rdata & w_mask) | ((r_ld_signed && w_sbit) ? ~w_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sb_addr[r_wr_ptr] <= in_addr;
      r_sb_data[r_wr_ptr] <= in_wdata;
      r_sb_size[r_wr_ptr] <= in_mem_size;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_ld_addr   <= '0;
      r_ld_size   <= '0;
      r_ld_signed <= 1'b0;
      r_ld_id     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_id     <= '0;
      r_wb_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_issue_ld) begin
        r_ld_addr   <= in_addr;
        r_ld_size   <= in_mem_size;
        r_ld_signed <= (in_mem_op == 2'd2);
        r_ld_id     <= in_inst_id;
      end
      if (w_capture) begin
        r_wb_rdata <= w_ext;
        r_done     <= 1'b1;
        r_done_id  <= r_ld_id;
      end else if (w_push) begin
        r_done     <= 1'b1;
        r_done_id  <= in_inst_id;
      end
      r_wb_valid <= in_valid && !stall;
      r_wb_id    <= in_inst_id;
    end
  end

  assign dreq_valid = (r_state == S_LD_REQ) || (r_state == S_ST_REQ);
  assign dreq_wen   = (r_state == S_ST_REQ);
  assign dreq_addr  = dreq_wen ? r_sb_addr[r_rd_ptr] : r_ld_addr;
  assign dreq_wdata = dreq_wen ? r_sb_data[r_rd_ptr] : '0;
  assign dreq_size  = dreq_wen ? r_sb_size[r_rd_ptr] : r_ld_size;

  assign wb_valid   = r_wb_valid;
  assign wb_inst_id = r_wb_id;
  assign wb_rdata   = r_wb_rdata;
  assign sb_count   = r_count;
  assign sb_empty   = w_sb_empty;

endmodule
